// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the shared-adder round-robin arbiter.
package adder_arb_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_DATA_W  = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Round-robin successor of winner w among n requesters.
  function automatic int unsigned next_ptr(input int unsigned w, input int unsigned n);
    return (w + 1) % n;
  endfunction

endpackage

// File: rtl/adder_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] win
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/adder_rr_arbiter.sv
// One wrap-around adder shared by NUM_REQ requesters with round-robin grant and a
// single registered response slot. ADDER_RR_ARBITER_CARRY_EN adds rsp_carry.
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter  int unsigned DATA_W  = DEF_DATA_W,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_sum,
  output logic [ID_W-1:0]           rsp_id
`ifdef ADDER_RR_ARBITER_CARRY_EN
  ,
  output logic                      rsp_carry
`endif
);

  state_t              state;
  logic [ID_W-1:0]     ptr;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     win;
  logic                can_accept;
  logic                accept;
  logic [DATA_W-1:0]   a_w;
  logic [DATA_W-1:0]   b_w;
  logic [DATA_W-1:0]   sum_w;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .win       (win)
  );

  assign rsp_valid  = (state == ST_FULL);
  assign can_accept = (state == ST_EMPTY) || (rsp_valid && rsp_ready);
  // Held low through reset so no requester sees an accept that cannot land.
  assign req_ready  = grant & {NUM_REQ{can_accept & rst_n}};
  assign accept     = |req_ready;

  // Operand mux for the winning requester.
  always_comb begin
    a_w = '0;
    b_w = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win) begin
        a_w = req_a[i*DATA_W +: DATA_W];
        b_w = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef ADDER_RR_ARBITER_CARRY_EN
  logic [DATA_W:0] sum_full;
  logic            carry_w;
  assign sum_full = {1'b0, a_w} + {1'b0, b_w};
  assign sum_w    = sum_full[DATA_W-1:0];
  assign carry_w  = sum_full[DATA_W];
`else
  assign sum_w = a_w + b_w;
`endif

  // Response slot and pointer; a drain and an accept in one cycle keep the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_EMPTY;
      rsp_sum <= '0;
      rsp_id  <= '0;
      ptr     <= '0;
`ifdef ADDER_RR_ARBITER_CARRY_EN
      rsp_carry <= 1'b0;
`endif
    end else if (accept) begin
      state   <= ST_FULL;
      rsp_sum <= sum_w;
      rsp_id  <= win;
      ptr     <= ID_W'(next_ptr(32'(win), NUM_REQ));
`ifdef ADDER_RR_ARBITER_CARRY_EN
      rsp_carry <= carry_w;
`endif
    end else if (rsp_valid && rsp_ready) begin
      state <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Randomized and directed self-checking bench for adder_rr_arbiter against a
// transaction-level reference model.
module tb_adder_rr_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_sum;
  logic [1:0]     rsp_id;
`ifdef ADDER_RR_ARBITER_CARRY_EN
  logic           rsp_carry;
`endif

  adder_rr_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id)
`ifdef ADDER_RR_ARBITER_CARRY_EN
    ,
    .rsp_carry (rsp_carry)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: an optional held transaction plus a scan start index.
  int m_ptr;
  bit m_held;
  int m_sum;
  int m_id;
  int m_carry;
  int exp_w;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_held = 0; m_sum = 0; m_id = 0; m_carry = 0;
  endtask

  task automatic set_req(input int i, input bit v, input int a, input int b);
    req_valid[i]     = v;
    req_a[i*W +: W]  = W'(a);
    req_b[i*W +: W]  = W'(b);
  endtask

  // One clock: check the grant from the current inputs, advance the model on the
  // edge, then check the response slot.
  task automatic tick();
    int exp_ready;
    int a, b;
    #1;
    exp_w = -1;
    if (!m_held || rsp_ready) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (exp_w < 0 && req_valid[j]) exp_w = j;
      end
    end
    exp_ready = (exp_w >= 0) ? (1 << exp_w) : 0;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    if (exp_w >= 0) begin
      a = int'(req_a[exp_w*W +: W]);
      b = int'(req_b[exp_w*W +: W]);
      m_held  = 1;
      m_sum   = (a + b) % 65536;
      m_carry = (a + b) / 65536;
      m_id    = exp_w;
      m_ptr   = (exp_w + 1) % N;
    end else if (m_held && rsp_ready) begin
      m_held = 0;
    end
    #2;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_held));
    chk("rsp_sum", 32'(rsp_sum), 32'(m_sum));
    chk("rsp_id", 32'(rsp_id), 32'(m_id));
`ifdef ADDER_RR_ARBITER_CARRY_EN
    chk("rsp_carry", 32'(rsp_carry), 32'(m_carry));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] held_sum;
    logic [1:0]   held_id;
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1; rst_n = 1'b1;
    model_reset();

    // Reset then idle
    do_reset();
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    tick();
    tick();

    // Single request on requester 0
    set_req(0, 1, 'h1234, 'h0101);
    tick();
    chk("single_sum", 32'(rsp_sum), 32'h1335);
    chk("single_id", 32'(rsp_id), 32'd0);
    set_req(0, 0, 0, 0);

    // Wrap-around on requester 2
    set_req(2, 1, 'hFFFF, 'h0003);
    tick();
    chk("wrap_sum", 32'(rsp_sum), 32'h0002);
    chk("wrap_id", 32'(rsp_id), 32'd2);
`ifdef ADDER_RR_ARBITER_CARRY_EN
    chk("wrap_carry", 32'(rsp_carry), 32'd1);
`endif
    set_req(2, 1, 'hFFFF, 'h0001);
    tick();
    chk("ovf_sum", 32'(rsp_sum), 32'h0000);
    set_req(2, 0, 0, 0);
    tick();

    // Round-robin from a fresh pointer: 0,1,2,3,0
    @(negedge clk);
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1, 16 * i + 1, 2);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rr_order", 32'(rsp_id), 32'(c % N));
      chk("rr_valid", 32'(rsp_valid), 32'd1);
    end

    // Backpressure: slot full, requester 1 waiting
    req_valid = '0;
    set_req(1, 1, 'h00AA, 'h0055);
    rsp_ready = 1'b0;
    held_sum = rsp_sum;
    held_id  = rsp_id;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_sum_stable", 32'(rsp_sum), 32'(held_sum));
      chk("bp_id_stable", 32'(rsp_id), 32'(held_id));
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'b0010);
    tick();
    chk("bp_no_bubble_valid", 32'(rsp_valid), 32'd1);
    chk("bp_no_bubble_sum", 32'(rsp_sum), 32'h00FF);
    chk("bp_no_bubble_id", 32'(rsp_id), 32'd1);

    // Async reset while full with pointer at 3
    req_valid = '0;
    set_req(2, 1, 'h0010, 'h0020);
    tick();
    chk("pre_rst_ptr3_id", 32'(rsp_id), 32'd2);
    rsp_ready = 1'b0;
    req_valid = '1;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    tick();
    chk("post_rst_first", 32'(rsp_id), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        int a, b;
        a = ($urandom_range(0, 7) == 0) ? 'hFFFF : int'($urandom_range(0, 65535));
        b = int'($urandom_range(0, 65535));
        set_req(i, ($urandom_range(0, 2) != 0), a, b);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
